uart_frame_rx: RTL and testbench

- Packet deframer directly downstream of the UART RX FIFO.
- Pops bytes through the FIFO's ready/byte/read interface and hunts for a sync byte. Parses the length, buffers the payload and checks an 8-bit checksum.
- Only checksum-good frames are released, on a valid/ready byte stream with a last flag.
- While a frame drains, input is not consumed; the UART RX FIFO absorbs the backpressure.

---
 rtl/uart_frame_rx.sv | 210 +++++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: packet deframer sitting behind the UART RX FIFO.
// Hunts for SYNC_BYTE, reads a length byte, buffers the payload, checks an
// 8-bit two's-complement checksum and releases only good frames on a
// valid/ready byte stream with a last flag.
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   rx_ready/rx_byte FIFO head byte and its availability
//   rx_read          combinational pop strobe to the FIFO
//   out_valid/out_ready/out_data/out_last  payload stream (registered)
//   frame_err        one-cycle pulse per discarded frame
//   err_code         1=length, 2=checksum, 3=timeout; holds until next error
//   frames_ok/frames_bad  saturating frame counters
module uart_frame_rx #(
  parameter int unsigned MAX_LEN        = 32,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ready,
  input  logic [7:0]  rx_byte,
  output logic        rx_read,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_HUNT  = 3'd0,
    S_LEN   = 3'd1,
    S_PAY   = 3'd2,
    S_CHK   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, idx_q, ridx_q;
  logic [7:0]      sum_q;
  logic [TW-1:0]   tmo_q;
  logic [7:0]      mem [MAX_LEN];

  logic            accept_st, in_frame, tmo_hit, pop, hand;
  logic            len_bad, chk_ok;
  logic [LW-1:0]   len_last, ridx_nxt;

  logic            out_valid_d, out_last_d, frame_err_d;
  logic [7:0]      out_data_d;
  logic [1:0]      err_code_d;
  logic            ok_inc, bad_inc;

  // Handshake and decode helpers shared by all processes
  always_comb begin
    accept_st = (state_q == S_HUNT) || (state_q == S_LEN) ||
                (state_q == S_PAY)  || (state_q == S_CHK);
    in_frame  = (state_q == S_LEN) || (state_q == S_PAY) || (state_q == S_CHK);
    // Timeout wins over a byte arriving in the same cycle: that byte stays queued
    tmo_hit   = in_frame && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    rx_read   = rst && rx_ready && accept_st && !tmo_hit;
    pop       = rx_read;
    hand      = out_valid && out_ready;
    len_bad   = (rx_byte == 8'h00) || (rx_byte > 8'(MAX_LEN));
    chk_ok    = (8'(sum_q + rx_byte) == 8'h00);
    len_last  = LW'(len_q - LW'(1));
    ridx_nxt  = LW'(ridx_q + LW'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_HUNT;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HUNT: begin
        if (pop && (rx_byte == SYNC_BYTE)) state_d = S_LEN;
      end
      S_LEN: begin
        if (tmo_hit)  state_d = S_HUNT;
        else if (pop) state_d = len_bad ? S_HUNT : S_PAY;
      end
      S_PAY: begin
        if (tmo_hit)                         state_d = S_HUNT;
        else if (pop && (idx_q == len_last)) state_d = S_CHK;
      end
      S_CHK: begin
        if (tmo_hit)  state_d = S_HUNT;
        else if (pop) state_d = chk_ok ? S_DRAIN : S_HUNT;
      end
      S_DRAIN: begin
        if (hand && out_last) state_d = S_HUNT;
      end
      default: state_d = S_HUNT;
    endcase
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_last_d  = out_last;
    frame_err_d = 1'b0;
    err_code_d  = err_code;
    ok_inc      = 1'b0;
    bad_inc     = 1'b0;
    case (state_q)
      S_LEN, S_PAY, S_CHK: begin
        if (tmo_hit) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd3;
          bad_inc     = 1'b1;
        end else if (pop && (state_q == S_LEN) && len_bad) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd1;
          bad_inc     = 1'b1;
        end else if (pop && (state_q == S_CHK)) begin
          if (chk_ok) begin
            ok_inc      = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = mem[0];
            out_last_d  = (len_q == LW'(1));
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
            bad_inc     = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (hand) begin
          if (out_last) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            out_data_d = mem[ridx_nxt[AW-1:0]];
            out_last_d = (ridx_nxt == len_last);
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and frame counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_last   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'd0;
      frames_ok  <= 16'h0000;
      frames_bad <= 16'h0000;
    end else begin
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_last  <= out_last_d;
      frame_err <= frame_err_d;
      err_code  <= err_code_d;
      if (ok_inc && (frames_ok != 16'hFFFF))   frames_ok  <= frames_ok + 16'd1;
      if (bad_inc && (frames_bad != 16'hFFFF)) frames_bad <= frames_bad + 16'd1;
    end
  end

  // Frame datapath: length, write/read indices, running sum
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q  <= '0;
      idx_q  <= '0;
      ridx_q <= '0;
      sum_q  <= 8'h00;
    end else begin
      if (pop && (state_q == S_LEN) && !len_bad) begin
        len_q <= LW'(rx_byte);
        sum_q <= rx_byte;
        idx_q <= '0;
      end
      if (pop && (state_q == S_PAY)) begin
        sum_q <= 8'(sum_q + rx_byte);
        idx_q <= LW'(idx_q + LW'(1));
      end
      if (pop && (state_q == S_CHK)) ridx_q <= '0;
      if ((state_q == S_DRAIN) && hand) ridx_q <= ridx_nxt;
    end
  end

  // Inter-byte timeout counter; idle outside LEN/PAY/CHK
  always_ff @(posedge clk) begin
    if (!rst)                            tmo_q <= '0;
    else if (!in_frame || pop || tmo_hit) tmo_q <= '0;
    else                                 tmo_q <= TW'(tmo_q + TW'(1));
  end

  // Payload buffer, no reset needed
  always_ff @(posedge clk) begin
    if (pop && (state_q == S_PAY)) mem[idx_q[AW-1:0]] <= rx_byte;
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed testbench for uart_frame_rx with a small FIFO model on the input
// side and a stream collector on the output side.
module tb_uart_frame_rx;

  logic        clk;
  logic        rst;
  logic        rx_ready;
  logic [7:0]  rx_byte;
  logic        rx_read;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] frames_ok;
  logic [15:0] frames_bad;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] q_in[$];
  int         pops;
  int         pop_cyc;
  bit         pop_pend;

  logic [7:0] out_d[$];
  bit         out_l[$];
  int         err_pulses = 0;
  int         err_cyc = 0;
  int         valid_cycles = 0;
  int         bad_read = 0;

  uart_frame_rx #(
    .MAX_LEN(32),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_ready(rx_ready),
    .rx_byte(rx_byte),
    .rx_read(rx_read),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .frame_err(frame_err),
    .err_code(err_code),
    .frames_ok(frames_ok),
    .frames_bad(frames_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: commits the previous cycle's pop, then presents the head
  initial begin
    rx_ready = 1'b0;
    rx_byte  = 8'h00;
    pop_pend = 1'b0;
    pops     = 0;
    pop_cyc  = 0;
    forever begin
      @(negedge clk);
      #1;
      if (pop_pend) begin
        void'(q_in.pop_front());
        pops++;
        pop_cyc = cyc;
      end
      rx_ready = (q_in.size() > 0);
      rx_byte  = rx_ready ? q_in[0] : 8'h00;
      #1;
      pop_pend = rx_ready && rx_read;
    end
  end

  // Output collector and event counters
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
        out_d.push_back(out_data);
        out_l.push_back(out_last);
      end
      if (frame_err) begin
        err_pulses++;
        err_cyc = cyc;
      end
      if (out_valid) valid_cycles++;
      if (out_valid && rx_read) bad_read++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 500000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    q_in.push_back(b);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    out_ready = 1'b0;
    tick(3);
    #3;
    checks++;
    if ({rx_read, out_valid, out_last, frame_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 0000", {rx_read, out_valid, out_last, frame_err});
    end
    checks++;
    if (err_code !== 2'd0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_code_data: got code %0d data %0h expected 0 0", err_code, out_data);
    end
    checks++;
    if (frames_ok !== 16'd0 || frames_bad !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got ok %0d bad %0d expected 0 0", frames_ok, frames_bad);
    end
    tick(1);
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_good_frame();
    int p0;
    logic [7:0] exp_d[3];
    bit exp_l[3];
    exp_d = '{8'h11, 8'h22, 8'h33};
    exp_l = '{1'b0, 1'b0, 1'b1};
    out_d.delete();
    out_l.delete();
    out_ready = 1'b1;
    p0 = pops;
    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h97);
    tick(25);
    #3;
    checks++;
    if (out_d.size() !== 3) begin
      errors++;
      $display("FAIL good_count: got %0d bytes expected 3", out_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (out_d[i] !== exp_d[i] || out_l[i] !== exp_l[i]) begin
          errors++;
          $display("FAIL good_byte%0d: got %0h last %0b expected %0h last %0b",
                   i, out_d[i], out_l[i], exp_d[i], exp_l[i]);
        end
      end
    end
    checks++;
    if (frames_ok !== 16'd1) begin
      errors++;
      $display("FAIL good_frames_ok: got %0d expected 1", frames_ok);
    end
    checks++;
    if (pops - p0 !== 6) begin
      errors++;
      $display("FAIL good_pops: got %0d expected 6", pops - p0);
    end
    checks++;
    if (err_pulses !== 0) begin
      errors++;
      $display("FAIL good_no_err: got %0d pulses expected 0", err_pulses);
    end
  endtask

  task automatic test_drop_single();
    int e0;
    out_d.delete();
    out_l.delete();
    e0 = err_pulses;
    push(8'h00); push(8'hFF); push(8'hA5); push(8'h01); push(8'h7F); push(8'h80);
    tick(25);
    #3;
    checks++;
    if (out_d.size() !== 1) begin
      errors++;
      $display("FAIL single_count: got %0d bytes expected 1", out_d.size());
    end else begin
      checks++;
      if (out_d[0] !== 8'h7F || out_l[0] !== 1'b1) begin
        errors++;
        $display("FAIL single_byte: got %0h last %0b expected 7f last 1", out_d[0], out_l[0]);
      end
    end
    checks++;
    if (err_pulses !== e0 || frames_ok !== 16'd2) begin
      errors++;
      $display("FAIL single_status: got err %0d ok %0d expected err %0d ok 2", err_pulses, frames_ok, e0);
    end
  endtask

  task automatic test_bad_checksum();
    int e0, v0;
    out_d.delete();
    out_l.delete();
    e0 = err_pulses;
    v0 = valid_cycles;
    push(8'hA5); push(8'h02); push(8'h10); push(8'h20); push(8'h00);
    tick(20);
    #3;
    checks++;
    if (err_pulses - e0 !== 1 || err_code !== 2'd2) begin
      errors++;
      $display("FAIL chk_err: got pulses %0d code %0d expected 1 2", err_pulses - e0, err_code);
    end
    checks++;
    if (frames_bad !== 16'd1) begin
      errors++;
      $display("FAIL chk_frames_bad: got %0d expected 1", frames_bad);
    end
    checks++;
    if (valid_cycles !== v0) begin
      errors++;
      $display("FAIL chk_no_valid: got %0d valid cycles expected 0", valid_cycles - v0);
    end
    push(8'hA5); push(8'h01); push(8'h05); push(8'hFA);
    tick(20);
    #3;
    checks++;
    if (out_d.size() !== 1) begin
      errors++;
      $display("FAIL chk_recover_count: got %0d expected 1", out_d.size());
    end else begin
      checks++;
      if (out_d[0] !== 8'h05 || out_l[0] !== 1'b1) begin
        errors++;
        $display("FAIL chk_recover_byte: got %0h last %0b expected 05 last 1", out_d[0], out_l[0]);
      end
    end
    checks++;
    if (frames_ok !== 16'd3) begin
      errors++;
      $display("FAIL chk_frames_ok: got %0d expected 3", frames_ok);
    end
  endtask

  task automatic test_len_err();
    int e0;
    e0 = err_pulses;
    push(8'hA5); push(8'h00); push(8'hA5); push(8'h21);
    tick(20);
    #3;
    checks++;
    if (err_pulses - e0 !== 2 || err_code !== 2'd1) begin
      errors++;
      $display("FAIL len_err: got pulses %0d code %0d expected 2 1", err_pulses - e0, err_code);
    end
    checks++;
    if (frames_bad !== 16'd3) begin
      errors++;
      $display("FAIL len_frames_bad: got %0d expected 3", frames_bad);
    end
  endtask

  task automatic test_timeout();
    int e0;
    out_d.delete();
    out_l.delete();
    e0 = err_pulses;
    push(8'hA5); push(8'h04); push(8'h01);
    tick(70);
    #3;
    checks++;
    if (err_pulses - e0 !== 1 || err_code !== 2'd3) begin
      errors++;
      $display("FAIL tmo_err: got pulses %0d code %0d expected 1 3", err_pulses - e0, err_code);
    end
    checks++;
    if (err_cyc - pop_cyc !== 50) begin
      errors++;
      $display("FAIL tmo_latency: got %0d cycles expected 50", err_cyc - pop_cyc);
    end
    checks++;
    if (frames_bad !== 16'd4) begin
      errors++;
      $display("FAIL tmo_frames_bad: got %0d expected 4", frames_bad);
    end
    push(8'hA5); push(8'h01); push(8'h05); push(8'hFA);
    tick(20);
    #3;
    checks++;
    if (out_d.size() !== 1 || frames_ok !== 16'd4) begin
      errors++;
      $display("FAIL tmo_recover: got %0d bytes ok %0d expected 1 bytes ok 4", out_d.size(), frames_ok);
    end else begin
      checks++;
      if (out_d[0] !== 8'h05) begin
        errors++;
        $display("FAIL tmo_recover_byte: got %0h expected 05", out_d[0]);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [7:0] exp_d[5];
    bit exp_l[5];
    bit seen;
    exp_d = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'h55};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    out_d.delete();
    out_l.delete();
    bad_read = 0;
    push(8'hA5); push(8'h03); push(8'h01); push(8'h02); push(8'h03); push(8'hF7);
    push(8'hA5); push(8'h02); push(8'hAA); push(8'h55); push(8'hFF);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #3;
      if (out_d.size() >= 1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_first_byte: got no byte expected one within 40 cycles");
    end
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #2;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h02 || out_last !== 1'b0 || rx_read !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got v %0b d %0h l %0b rd %0b expected v 1 d 02 l 0 rd 0",
                 i, out_valid, out_data, out_last, rx_read);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    tick(40);
    #3;
    checks++;
    if (out_d.size() !== 5) begin
      errors++;
      $display("FAIL stall_count: got %0d bytes expected 5", out_d.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (out_d[i] !== exp_d[i] || out_l[i] !== exp_l[i]) begin
          errors++;
          $display("FAIL stall_byte%0d: got %0h last %0b expected %0h last %0b",
                   i, out_d[i], out_l[i], exp_d[i], exp_l[i]);
        end
      end
    end
    checks++;
    if (bad_read !== 0 || frames_ok !== 16'd6) begin
      errors++;
      $display("FAIL stall_status: got drain reads %0d ok %0d expected 0 6", bad_read, frames_ok);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    push(8'hA5); push(8'h05); push(8'h01); push(8'h02);
    tick(8);
    rst = 1'b0;
    #2;
    checks++;
    if (rx_read !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_read: got %0b expected 0", rx_read);
    end
    tick(2);
    #3;
    checks++;
    if ({out_valid, out_last, frame_err, err_code, out_data} !== 13'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got v %0b l %0b e %0b c %0d d %0h expected all 0",
               out_valid, out_last, frame_err, err_code, out_data);
    end
    checks++;
    if (frames_ok !== 16'd0 || frames_bad !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_counters: got ok %0d bad %0d expected 0 0", frames_ok, frames_bad);
    end
    e0 = err_pulses;
    @(negedge clk);
    rst = 1'b1;
    tick(60);
    #3;
    checks++;
    if (err_pulses !== e0 || frames_bad !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_no_err: got pulses %0d bad %0d expected 0 0", err_pulses - e0, frames_bad);
    end
  endtask

  initial begin
    rst = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_good_frame();
    test_drop_single();
    test_bad_checksum();
    test_len_err();
    test_timeout();
    test_back_to_back_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
